// File: rtl/mux_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined N:1 mux tree.
package mux_tree_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One registered 2:1 level of the mux tree; the full channel index rides along
// with each word and this level steers on bit (SEL_W - SEL_LEFT) of it.
module mux_tree_stage #(
    parameter int WIDTH    = 4,
    parameter int IN_CH    = 4,
    parameter int SEL_LEFT = 2,
    parameter int SEL_W    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [IN_CH*WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic                          in_valid,
    output logic [(IN_CH/2)*WIDTH-1:0]    out_data,
    output logic [SEL_W-1:0]              out_sel,
    output logic                          out_valid
);

    localparam int OUT_CH = IN_CH / 2;
    localparam int BIT    = SEL_W - SEL_LEFT;

    logic [OUT_CH*WIDTH-1:0] nxt;

    always_comb begin
        nxt = '0;
        for (int k = 0; k < OUT_CH; k++)
            nxt[k*WIDTH +: WIDTH] = in_sel[BIT] ? in_data[(2*k+1)*WIDTH +: WIDTH]
                                                : in_data[(2*k)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_data  <= nxt;
            out_sel   <= in_sel;
            out_valid <= in_valid;
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 word mux with valid/ready back-pressure and round-robin scan.
// Define MUX_CNT_EN to build the saturating delivered-beat counter.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    auto_mode,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        beat_cnt
);

    localparam int LEVELS = SEL_W;

    if (!is_pow2(NUM_CH)) begin : g_bad_cfg
        $error("mux_tree_pipe: NUM_CH must be a power of two >= 2");
    end

    logic                          adv, accept;
    logic [SEL_W-1:0]              rr_ptr;
    logic [LEVELS:0]               vld_pipe;
    logic [LEVELS:0][SEL_W-1:0]    sel_pipe;
    // Outputs of every level packed back to back, level 0 at the bottom.
    logic [(NUM_CH-1)*WIDTH-1:0]   tree_d;

    // One global enable: the whole tree slips together or holds together.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    assign vld_pipe[0] = accept;
    assign sel_pipe[0] = auto_mode ? rr_ptr : in_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (accept && auto_mode)
            rr_ptr <= rr_ptr + 1'b1;
    end

    for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
        localparam int IN_CH    = NUM_CH >> i;
        localparam int OFF_OUT  = (NUM_CH - (NUM_CH >> i)) * WIDTH;
        localparam int OFF_PREV = (i == 0) ? 0 : (NUM_CH - ((2 * NUM_CH) >> i)) * WIDTH;

        logic [IN_CH*WIDTH-1:0] d_in;

        if (i == 0) begin : g_src
            assign d_in = in_data;
        end else begin : g_src
            assign d_in = tree_d[OFF_PREV +: IN_CH*WIDTH];
        end

        mux_tree_stage #(
            .WIDTH    (WIDTH),
            .IN_CH    (IN_CH),
            .SEL_LEFT (SEL_W - i),
            .SEL_W    (SEL_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (adv),
            .in_data   (d_in),
            .in_sel    (sel_pipe[i]),
            .in_valid  (vld_pipe[i]),
            .out_data  (tree_d[OFF_OUT +: (IN_CH/2)*WIDTH]),
            .out_sel   (sel_pipe[i+1]),
            .out_valid (vld_pipe[i+1])
        );
    end

    assign out_data  = tree_d[(NUM_CH-2)*WIDTH +: WIDTH];
    assign out_ch    = sel_pipe[LEVELS];
    assign out_valid = vld_pipe[LEVELS];

`ifdef MUX_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (out_valid && out_ready && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
    end

    assign beat_cnt = cnt_q;
`else
    assign beat_cnt = '0;
`endif

endmodule
